adc_capture_core: RTL

Receive-side counterpart of the DAC output path. It accepts RFDC ADC samples on an AXI4-Stream slave port and starts capturing at a programmed 64-bit timestamp taken from the shared TimeController counter. Captured beats go into an internal buffer. The AXI front end drains the buffer as 128-bit words through a FIFO-style read port.

---
 rtl/adc_capture_core.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/adc_capture_core.sv
// adc_capture_core: timestamp-triggered ADC capture into a beat buffer,
// drained as half-beat words. Optional decimation: ADC_CAPTURE_DECIM_EN.
module adc_capture_core #(
    parameter int AXIS_DATA_WIDTH = 256,
    parameter int RD_DATA_WIDTH   = 128,
    parameter int BUF_DEPTH_LOG   = 10,
    parameter int LEN_WIDTH       = 16
) (
    input  logic                       s_axi_aclk,
    input  logic                       s_axi_aresetn,
    input  logic [AXIS_DATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                       s00_axis_tvalid,
    output logic                       s00_axis_tready,
    input  logic [63:0]                counter,
    input  logic [63:0]                cfg_start_time,
    input  logic [LEN_WIDTH-1:0]       cfg_length,
    input  logic [7:0]                 cfg_decim,
    input  logic                       arm,
    input  logic                       flush,
    input  logic                       rd_en,
    output logic [RD_DATA_WIDTH-1:0]   rd_data,
    output logic                       rd_valid,
    output logic                       empty,
    output logic [BUF_DEPTH_LOG+1:0]   words_avail,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow_error,
    output logic                       late_error,
    output logic [63:0]                capture_timestamp
);

    localparam int DEPTH = 1 << BUF_DEPTH_LOG;
    localparam int PW    = BUF_DEPTH_LOG + 1;
    localparam int WW    = BUF_DEPTH_LOG + 2;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [63:0]          start_q, start_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [63:0]          ts_q, ts_d;
    logic                 late_q, late_d;
    logic                 ovf_q, ovf_d;
    logic                 tready_q, tready_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic                 half_q, half_d;
    logic [RD_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;

    logic [AXIS_DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] level;
    logic [WW-1:0] words;
    logic          full;
    logic          cap_win;
    logic          beat_ok;
    logic          take;
    logic          wr_en;
    logic          rd_fire;
    logic          arm_ok;
    logic [AXIS_DATA_WIDTH-1:0] head;

`ifdef ADC_CAPTURE_DECIM_EN
    logic [7:0] dec_q, dec_d;
    logic [7:0] ph_q, ph_d;
    assign beat_ok = (ph_q == 8'd0);
`else
    logic unused_decim;
    assign unused_decim = ^cfg_decim;
    assign beat_ok = 1'b1;
`endif

    assign level   = wr_ptr_q - rd_ptr_q;
    assign words   = {level, 1'b0} - WW'(half_q);
    assign full    = (level == PW'(DEPTH));
    // The beat at counter==start_time is already part of the window.
    assign cap_win = (state_q == S_CAPTURE)
                   || ((state_q == S_ARMED) && (counter >= start_q));
    assign take    = cap_win && s00_axis_tvalid && beat_ok;
    assign wr_en   = take && !full && !flush;
    assign rd_fire = rd_en && (words != '0) && !flush;
    assign arm_ok  = arm && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign head    = mem_q[rd_ptr_q[BUF_DEPTH_LOG-1:0]];

    // Next-state logic: capture FSM, buffer pointers, read port, flags.
    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        ts_d       = ts_q;
        late_d     = late_q;
        ovf_d      = ovf_q;
        tready_d   = 1'b1;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        half_d     = half_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
`ifdef ADC_CAPTURE_DECIM_EN
        dec_d = dec_q;
        ph_d  = ph_q;
        if (cap_win && s00_axis_tvalid) begin
            ph_d = (ph_q == dec_q) ? 8'd0 : ph_q + 8'd1;
        end
`endif
        if (cap_win) begin
            state_d = S_CAPTURE;
        end
        if (take) begin
            if (cnt_q == '0) begin
                ts_d = counter;
            end
            cnt_d = cnt_q + 1'b1;
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (cnt_d == len_q) begin
                state_d = S_DONE;
            end
        end
        if (rd_fire) begin
            rd_valid_d = 1'b1;
            if (half_q) begin
                rd_data_d = head[AXIS_DATA_WIDTH-1:RD_DATA_WIDTH];
                rd_ptr_d  = rd_ptr_q + 1'b1;
            end else begin
                rd_data_d = head[RD_DATA_WIDTH-1:0];
            end
            half_d = ~half_q;
        end
        if (arm_ok) begin
            start_d = cfg_start_time;
            len_d   = cfg_length;
            cnt_d   = '0;
`ifdef ADC_CAPTURE_DECIM_EN
            dec_d = cfg_decim;
            ph_d  = 8'd0;
`endif
            if (counter > cfg_start_time) begin
                late_d = 1'b1;
            end
            if (cfg_length == '0) begin
                state_d = S_DONE;
            end else if (counter > cfg_start_time) begin
                state_d = S_CAPTURE;
            end else begin
                state_d = S_ARMED;
            end
        end
        if (flush) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            late_d     = 1'b0;
            ovf_d      = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            half_d     = 1'b0;
            rd_valid_d = 1'b0;
        end
    end

    // Control and status registers.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q    <= S_IDLE;
            start_q    <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            ts_q       <= '0;
            late_q     <= 1'b0;
            ovf_q      <= 1'b0;
            tready_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            half_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
`ifdef ADC_CAPTURE_DECIM_EN
            dec_q <= 8'd0;
            ph_q  <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            ts_q       <= ts_d;
            late_q     <= late_d;
            ovf_q      <= ovf_d;
            tready_q   <= tready_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            half_q     <= half_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
`ifdef ADC_CAPTURE_DECIM_EN
            dec_q <= dec_d;
            ph_q  <= ph_d;
`endif
        end
    end

    // Beat storage; contents need no reset since pointers gate visibility.
    always_ff @(posedge s_axi_aclk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[BUF_DEPTH_LOG-1:0]] <= s00_axis_tdata;
        end
    end

    assign s00_axis_tready   = tready_q;
    assign rd_data           = rd_data_q;
    assign rd_valid          = rd_valid_q;
    assign words_avail       = words;
    assign empty             = (words == '0);
    assign busy              = (state_q == S_ARMED) || (state_q == S_CAPTURE);
    assign done              = (state_q == S_DONE);
    assign overflow_error    = ovf_q;
    assign late_error        = late_q;
    assign capture_timestamp = ts_q;

endmodule
